// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: RAW-hazard scoreboard and stall/flush sequencing for a
// five-stage MIPS pipeline without forwarding.
//   clk, reset (async, active-low)
//   id_*              decode-stage instruction fields
//   mem_branch_taken  branch in MEM resolved taken
//   ext_hold          global freeze
//   cnt_clr           synchronous clear of the performance counters
//   *_en, *_flush, id_ex_bubble, stall   pipeline controls
//   stall_cnt, flush_cnt                 saturating performance counters
module pipeline_hazard_ctrl #(
  parameter int CNT_W     = 16,
  parameter bit WB_BYPASS = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_wr_en,
  input  logic [4:0]       id_wr_reg,
  input  logic             id_jump,
  input  logic             mem_branch_taken,
  input  logic             ext_hold,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_flush,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic       ex_v, mem_v, wb_v;
  logic [4:0] ex_r, mem_r, wb_r;
  logic       rs_hit, rt_hit, hazard, br, st, iss, jmp;
  // With WB_BYPASS the register bank writes before it reads, so WB never conflicts.
  always_comb begin
    rs_hit = id_uses_rs && id_rs != 5'd0 &&
             ((ex_v && ex_r == id_rs) || (mem_v && mem_r == id_rs) ||
              (!WB_BYPASS && wb_v && wb_r == id_rs));
    rt_hit = id_uses_rt && id_rt != 5'd0 &&
             ((ex_v && ex_r == id_rt) || (mem_v && mem_r == id_rt) ||
              (!WB_BYPASS && wb_v && wb_r == id_rt));
    hazard = id_valid && (rs_hit || rt_hit);
  end
  // Priority: hold > taken branch > hazard stall > issue (jump flush only on issue).
  assign br  = !ext_hold && mem_branch_taken;
  assign st  = !ext_hold && !br && hazard;
  assign iss = !ext_hold && !br && !hazard;
  assign jmp = iss && id_valid && id_jump;
  assign pc_en        = iss || br;
  assign if_id_en     = iss || br;
  assign id_ex_en     = !ext_hold;
  assign ex_mem_en    = !ext_hold;
  assign mem_wb_en    = !ext_hold;
  assign if_id_flush  = br || jmp;
  assign id_ex_bubble = br || st;
  assign ex_mem_flush = br;
  assign stall        = st;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_v      <= 1'b0;
      mem_v     <= 1'b0;
      wb_v      <= 1'b0;
      ex_r      <= 5'd0;
      mem_r     <= 5'd0;
      wb_r      <= 5'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!ext_hold) begin
        wb_v  <= mem_v;
        wb_r  <= mem_r;
        mem_v <= ex_v && !br;
        mem_r <= ex_r;
        ex_v  <= iss && id_valid && id_wr_en && id_wr_reg != 5'd0;
        ex_r  <= id_wr_reg;
      end
      stall_cnt <= cnt_clr ? '0 : (st && stall_cnt != CNT_MAX) ? stall_cnt + 1'b1 : stall_cnt;
      flush_cnt <= cnt_clr ? '0 : ((br || jmp) && flush_cnt != CNT_MAX) ? flush_cnt + 1'b1 : flush_cnt;
    end
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the five-stage segmented MIPS core (IF, ID, EX, MEM, WB); the datapath has no forwarding.
- Keeps a scoreboard of destination registers for instructions in flight and detects RAW hazards at decode.
- Drives per-stage register enables, bubble and flush controls for stalls, taken branches (resolved in MEM) and jumps (resolved in ID).
- Provides saturating stall and flush counters for performance measurement.

Parameters:
- CNT_W, 16, width of stall_cnt and flush_cnt.
- WB_BYPASS, 1, 1 = register bank writes before it reads in the same cycle, so the WB entry is excluded from hazard compare; 0 = WB entry is included.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  5  ID source register rs.
- id_rt  in  5  ID source register rt.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_wr_en  in  1  ID instruction writes the register bank.
- id_wr_reg  in  5  ID destination register, after the RegDest mux.
- id_jump  in  1  ID instruction is an unconditional jump.
- mem_branch_taken  in  1  branch in MEM resolved taken.
- ext_hold  in  1  global freeze, e.g. memory not ready.
- cnt_clr  in  1  synchronous clear of both counters.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF/ID register enable.
- id_ex_en  out  1  ID/EX register enable.
- ex_mem_en  out  1  EX/MEM register enable.
- mem_wb_en  out  1  MEM/WB register enable.
- if_id_flush  out  1  load a NOP into IF/ID.
- id_ex_bubble  out  1  load a NOP into ID/EX.
- ex_mem_flush  out  1  load a NOP into EX/MEM.
- stall  out  1  decode stall this cycle.
- stall_cnt  out  CNT_W  stall cycles counted.
- flush_cnt  out  CNT_W  flush events counted.

Behaviour:
- Scoreboard: three entries, sb_ex, sb_mem, sb_wb, each holding {valid, reg[4:0]}. An entry is valid only if its instruction writes a register and reg != 0.
- Reset (reset=0, asynchronous): all entries invalid; stall_cnt=0; flush_cnt=0.
  - Outputs are combinational from state and inputs. With idle inputs after reset: all enables=1, all flush/bubble signals=0, stall=0.
- Hazard: id_valid, AND (id_uses_rs with id_rs!=0 matching a valid entry) OR (id_uses_rt with id_rt!=0 matching a valid entry).
  - Entries compared: sb_ex and sb_mem; sb_wb as well only when WB_BYPASS=0.
- Priority, highest first:
  - 1. ext_hold=1: all enables=0; flush, bubble and stall outputs=0; scoreboard and counters frozen. A taken branch or jump stays pending, since its inputs are re-presented.
  - 2. mem_branch_taken=1: all enables=1; if_id_flush=1; id_ex_bubble=1; ex_mem_flush=1; stall=0.
    - Next state: sb_wb<=sb_mem, sb_mem<=invalid, sb_ex<=invalid.
    - flush_cnt increments by 1.
    - Any ID stall or jump in the same cycle is discarded, because the ID instruction is killed.
  - 3. Hazard=1: stall=1; pc_en=0; if_id_en=0; id_ex_en=1; id_ex_bubble=1; ex_mem_en=1; mem_wb_en=1.
    - Next state: sb_wb<=sb_mem, sb_mem<=sb_ex, sb_ex<=invalid.
    - stall_cnt increments by 1.
    - Any id_jump is ignored until the instruction issues.
  - 4. Otherwise, issue: all enables=1.
    - Next state: sb_ex<={id_valid & id_wr_en & id_wr_reg!=0, id_wr_reg}; the other entries shift.
    - If id_valid & id_jump: if_id_flush=1 and flush_cnt increments by 1.
- Counters:
  - Both saturate at 2^CNT_W-1 and never wrap.
  - cnt_clr=1 clears both counters and overrides an increment in the same cycle.
  - ext_hold does not block cnt_clr.
- Stall latency (WB_BYPASS=1):
  - Consumer immediately behind its producer: 2 stall cycles.
  - One instruction gap: 1 stall cycle.
  - Two or more instructions gap: 0 stall cycles.
  - With WB_BYPASS=0, each of these figures increases by 1.
- Reset asserted mid-stall: state clears immediately. After release there is no stall until a new producer issues.

Test Plan:
- Issue a write to r3, then an instruction reading rs=r3, WB_BYPASS=1 -> stall=1 for exactly 2 cycles, pc_en=0 during those cycles, id_ex_bubble=1 during those cycles, stall_cnt=2, consumer issues on cycle 3.
- Producer writing r0, then a consumer reading r0 -> no stall, stall_cnt=0; one independent instruction between producer r5 and consumer r5 -> 1 stall cycle.
- Hazard pending and mem_branch_taken=1 in the same cycle -> if_id_flush, id_ex_bubble and ex_mem_flush all =1; stall=0; flush_cnt=1; next cycle sb_ex and sb_mem are invalid.
- id_jump=1 with no hazard -> if_id_flush=1 for 1 cycle, flush_cnt=1; id_jump=1 during a hazard -> no flush until the stall ends.
- ext_hold=1 for 3 cycles during a 2-cycle stall -> all enables=0 and counters unchanged while held; stall resumes and finishes 2 cycles after hold drops, stall_cnt=2.
- Preload stall_cnt near saturation (CNT_W=4) and force 20 stall cycles -> stall_cnt holds at 15; cnt_clr=1 -> 0. Drop reset mid-stall -> stall=0 asynchronously and counters=0.
